// File: rtl/simd_lane_pkg.sv
// rtl/simd_lane_pkg.sv - shared opcodes, ALU encodings and control bundle for the nibble-serial SIMD lane
package simd_lane_pkg;

    localparam int P_NBITS   = 4;
    localparam int C_N_OFF   = 8;
    localparam int C_OFFBITS = 3;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_BNE = 3'd5;

    localparam logic [1:0] ALU_ARITH = 2'b00;
    localparam logic [1:0] ALU_LOGIC = 2'b01;
    localparam logic [1:0] ALU_SHIFT = 2'b10;
    localparam logic [1:0] ALU_JALR  = 2'b11;

    localparam logic [1:0] LFN_AND = 2'b00;
    localparam logic [1:0] LFN_OR  = 2'b01;
    localparam logic [1:0] LFN_XOR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic       wb_en;
        logic       addsub_fn;
        logic [1:0] logic_fn;
        logic [1:0] alu_fn_type;
        logic       prop_carry;
        logic       carry_in_1;
        logic       flag_reg_en;
        logic       br_reg_en;
        logic       last_uop;
        logic       b_mux_sel;
    } uop_ctrl_t;

endpackage

// File: rtl/simd_uop_decode.sv
// rtl/simd_uop_decode.sv - combinational per-beat control decode for one nibble micro-op
module simd_uop_decode
    import simd_lane_pkg::*;
(
    input  logic [2:0]           op,
    input  logic [C_OFFBITS-1:0] beat,
    input  logic                 last,
    output uop_ctrl_t            ctrl
);

    always_comb begin
        ctrl           = '0;
        ctrl.b_mux_sel = 1'b1;
        ctrl.last_uop  = last;
        case (op)
            OP_ADD, OP_SUB, OP_BNE: begin
                // BNE is a SUB whose only architectural effect is the flag/branch chain
                ctrl.alu_fn_type = ALU_ARITH;
                ctrl.addsub_fn   = (op != OP_ADD);
                ctrl.prop_carry  = (beat != '0);
                ctrl.carry_in_1  = (beat == '0) && (op != OP_ADD);
                ctrl.flag_reg_en = 1'b1;
                ctrl.wb_en       = (op != OP_BNE);
                ctrl.br_reg_en   = (op == OP_BNE) && last;
            end
            OP_AND, OP_OR, OP_XOR: begin
                ctrl.alu_fn_type = ALU_LOGIC;
                ctrl.logic_fn    = (op == OP_AND) ? LFN_AND :
                                   (op == OP_OR)  ? LFN_OR  : LFN_XOR;
                ctrl.wb_en       = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/simd_lane_uop_sequencer.sv
// rtl/simd_lane_uop_sequencer.sv - 8-beat nibble micro-op sequencer; SIMD_SEQ_BACK2BACK_EN enables accept on the last beat
module simd_lane_uop_sequencer
    import simd_lane_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_val,
    output logic                 req_rdy,
    input  logic [2:0]           req_op,
    input  logic [4:0]           req_rs1,
    input  logic [4:0]           req_rs2,
    input  logic [4:0]           req_rd,
    output logic [4:0]           rega_addr_Rhl,
    output logic [4:0]           regb_addr_Rhl,
    output logic [C_OFFBITS-1:0] a_subword_off_Rhl,
    output logic [C_OFFBITS-1:0] b_subword_off_Rhl,
    output logic                 wb_en_Xhl,
    output logic [4:0]           wb_addr_Xhl,
    output logic [C_OFFBITS-1:0] wb_subword_off_Xhl,
    output logic                 addsub_fn_Xhl,
    output logic [1:0]           logic_fn_Xhl,
    output logic [1:0]           alu_fn_type_Xhl,
    output logic                 prop_carry_Xhl,
    output logic                 carry_in_1_Xhl,
    output logic                 flag_reg_en_Xhl,
    output logic                 br_reg_en_Xhl,
    output logic                 last_uop_Xhl,
    output logic                 b_mux_sel_Xhl,
    output logic                 done
);

    localparam logic [C_OFFBITS-1:0] K_LAST = C_OFFBITS'(C_N_OFF - 1);

    seq_state_t           state_q, state_d;
    logic [C_OFFBITS-1:0] k_q, k_d;
    logic [2:0]           op_q;
    logic [4:0]           rs1_q, rs2_q, rd_q;

    logic      accept, r_valid, r_last;
    uop_ctrl_t dec_ctrl, r_ctrl;

    uop_ctrl_t            x_ctrl_q;
    logic [4:0]           x_wb_addr_q;
    logic [C_OFFBITS-1:0] x_wb_off_q;

    assign r_valid = (state_q == S_RUN);
    assign r_last  = r_valid && (k_q == K_LAST);

    // req_rdy is gated by reset so it reads 0 the instant reset asserts
`ifdef SIMD_SEQ_BACK2BACK_EN
    assign req_rdy = reset && ((state_q == S_IDLE) || r_last);
`else
    assign req_rdy = reset && (state_q == S_IDLE);
`endif
    assign accept = req_val && req_rdy;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_RUN;
                    k_d     = '0;
                end
            end
            S_RUN: begin
                k_d = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    state_d = accept ? S_RUN : S_DRAIN;
                    k_d     = '0;
                end
            end
            S_DRAIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            op_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            if (accept) begin
                op_q  <= req_op;
                rs1_q <= req_rs1;
                rs2_q <= req_rs2;
                rd_q  <= req_rd;
            end
        end
    end

    simd_uop_decode u_decode (
        .op   (op_q),
        .beat (k_q),
        .last (r_last),
        .ctrl (dec_ctrl)
    );

    always_comb begin
        r_ctrl       = dec_ctrl;
        r_ctrl.wb_en = dec_ctrl.wb_en && (rd_q != 5'd0);
        if (!r_valid)
            r_ctrl = '0;
    end

    assign rega_addr_Rhl     = r_valid ? rs1_q : 5'd0;
    assign regb_addr_Rhl     = r_valid ? rs2_q : 5'd0;
    assign a_subword_off_Rhl = r_valid ? k_q : '0;
    assign b_subword_off_Rhl = r_valid ? k_q : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_ctrl_q    <= '0;
            x_wb_addr_q <= '0;
            x_wb_off_q  <= '0;
        end else begin
            x_ctrl_q    <= r_ctrl;
            x_wb_addr_q <= r_valid ? rd_q : 5'd0;
            x_wb_off_q  <= r_valid ? k_q : '0;
        end
    end

    assign wb_en_Xhl          = x_ctrl_q.wb_en;
    assign wb_addr_Xhl        = x_wb_addr_q;
    assign wb_subword_off_Xhl = x_wb_off_q;
    assign addsub_fn_Xhl      = x_ctrl_q.addsub_fn;
    assign logic_fn_Xhl       = x_ctrl_q.logic_fn;
    assign alu_fn_type_Xhl    = x_ctrl_q.alu_fn_type;
    assign prop_carry_Xhl     = x_ctrl_q.prop_carry;
    assign carry_in_1_Xhl     = x_ctrl_q.carry_in_1;
    assign flag_reg_en_Xhl    = x_ctrl_q.flag_reg_en;
    assign br_reg_en_Xhl      = x_ctrl_q.br_reg_en;
    assign last_uop_Xhl       = x_ctrl_q.last_uop;
    assign b_mux_sel_Xhl      = x_ctrl_q.b_mux_sel;
    assign done               = x_ctrl_q.last_uop;

endmodule

// File: tb/tb_simd_lane_uop_sequencer.sv
// tb/tb_simd_lane_uop_sequencer.sv - scoreboard bench for simd_lane_uop_sequencer
module tb_simd_lane_uop_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req_val = 1'b0;
    logic       req_rdy;
    logic [2:0] req_op = '0;
    logic [4:0] req_rs1 = '0, req_rs2 = '0, req_rd = '0;
    logic [4:0] rega_addr_Rhl, regb_addr_Rhl, wb_addr_Xhl;
    logic [2:0] a_subword_off_Rhl, b_subword_off_Rhl, wb_subword_off_Xhl;
    logic       wb_en_Xhl, addsub_fn_Xhl, prop_carry_Xhl, carry_in_1_Xhl;
    logic [1:0] logic_fn_Xhl, alu_fn_type_Xhl;
    logic       flag_reg_en_Xhl, br_reg_en_Xhl, last_uop_Xhl, b_mux_sel_Xhl, done;

    int errors = 0;
    int checks = 0;
    logic [19:0] sb[$];

`ifdef SIMD_SEQ_BACK2BACK_EN
    localparam int B2B = 1;
    localparam int GAP = 8;
`else
    localparam int B2B = 0;
    localparam int GAP = 10;
`endif

    simd_lane_uop_sequencer dut (
        .clk(clk), .reset(reset), .req_val(req_val), .req_rdy(req_rdy),
        .req_op(req_op), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
        .rega_addr_Rhl(rega_addr_Rhl), .regb_addr_Rhl(regb_addr_Rhl),
        .a_subword_off_Rhl(a_subword_off_Rhl), .b_subword_off_Rhl(b_subword_off_Rhl),
        .wb_en_Xhl(wb_en_Xhl), .wb_addr_Xhl(wb_addr_Xhl), .wb_subword_off_Xhl(wb_subword_off_Xhl),
        .addsub_fn_Xhl(addsub_fn_Xhl), .logic_fn_Xhl(logic_fn_Xhl), .alu_fn_type_Xhl(alu_fn_type_Xhl),
        .prop_carry_Xhl(prop_carry_Xhl), .carry_in_1_Xhl(carry_in_1_Xhl),
        .flag_reg_en_Xhl(flag_reg_en_Xhl), .br_reg_en_Xhl(br_reg_en_Xhl),
        .last_uop_Xhl(last_uop_Xhl), .b_mux_sel_Xhl(b_mux_sel_Xhl), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {wb_en, wb_addr, wb_off, addsub, logic_fn, alu_type, prop, cin, flag, br, last, bmux}
    function automatic logic [19:0] model(input logic [2:0] op, input logic [4:0] rd, input int k);
        logic arith, sub, lg, wb;
        logic [1:0] lfn, alu;
        arith = (op == 3'd0) || (op == 3'd1) || (op == 3'd5);
        sub   = (op == 3'd1) || (op == 3'd5);
        lg    = (op == 3'd2) || (op == 3'd3) || (op == 3'd4);
        wb    = ((arith && op != 3'd5) || lg) && (rd != 5'd0);
        lfn   = (op == 3'd3) ? 2'b01 : (op == 3'd4) ? 2'b10 : 2'b00;
        alu   = lg ? 2'b01 : 2'b00;
        return {wb, rd, 3'(k), sub, lfn, alu, arith && (k != 0), sub && (k == 0),
                arith, (op == 3'd5) && (k == 7), k == 7, 1'b1};
    endfunction

    function automatic logic [19:0] xobs();
        return {wb_en_Xhl, wb_addr_Xhl, wb_subword_off_Xhl, addsub_fn_Xhl, logic_fn_Xhl,
                alu_fn_type_Xhl, prop_carry_Xhl, carry_in_1_Xhl, flag_reg_en_Xhl,
                br_reg_en_Xhl, last_uop_Xhl, b_mux_sel_Xhl};
    endfunction

    task automatic wait_rdy();
        for (int i = 0; i < 30 && req_rdy !== 1'b1; i++) @(negedge clk);
        chk("rdy_wait", 32'(req_rdy), 1);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd);
        wait_rdy();
        req_val = 1'b1; req_op = op; req_rs1 = rs1; req_rs2 = rs2; req_rd = rd;
        for (int k = 0; k < 8; k++) sb.push_back(model(op, rd, k));
        @(negedge clk);
        req_val = 1'b0; req_op = ~op; req_rs1 = ~rs1; req_rs2 = ~rs2; req_rd = ~rd;
        for (int c = 1; c <= 10; c++) begin
            if (c <= 8) begin
                chk("r_rega", 32'(rega_addr_Rhl), 32'(rs1));
                chk("r_regb", 32'(regb_addr_Rhl), 32'(rs2));
                chk("r_aoff", 32'(a_subword_off_Rhl), 32'(c - 1));
                chk("r_boff", 32'(b_subword_off_Rhl), 32'(c - 1));
            end else begin
                chk("r_idle", {16'd0, rega_addr_Rhl, regb_addr_Rhl, a_subword_off_Rhl, b_subword_off_Rhl}, 0);
            end
            if (c >= 2 && c <= 9) begin
                if (sb.size() == 0) chk("sb_empty", 1, 0);
                else chk("x_beat", 32'(xobs()), 32'(sb.pop_front()));
            end else begin
                chk("x_idle", 32'(xobs()), 0);
            end
            chk("done", 32'(done), 32'(c == 9));
            chk("req_rdy", 32'(req_rdy), 32'((c == 10) || (B2B == 1 && c == 8)));
            if (c < 10) @(negedge clk);
        end
    endtask

    initial begin
        int acc[2];
        int n, dones, wbs;

        // reset asserted: everything low, including req_rdy
        #2;
        chk("rst_rdy", 32'(req_rdy), 0);
        chk("rst_x", 32'(xobs()), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_r", {16'd0, rega_addr_Rhl, regb_addr_Rhl, a_subword_off_Rhl, b_subword_off_Rhl}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1 chk("rel_rdy", 32'(req_rdy), 1);

        run_op(3'd0, 5'd1, 5'd2, 5'd3);   // ADD
        run_op(3'd1, 5'd7, 5'd8, 5'd5);   // SUB
        run_op(3'd5, 5'd4, 5'd6, 5'd9);   // BNE
        run_op(3'd0, 5'd10, 5'd11, 5'd0); // ADD to x0
        run_op(3'd7, 5'd12, 5'd13, 5'd3); // unknown opcode
        run_op(3'd3, 5'd14, 5'd15, 5'd16);// OR
        run_op(3'd2, 5'd17, 5'd18, 5'd19);// AND

        // XOR aborted by reset in cycle 5
        wait_rdy();
        req_val = 1'b1; req_op = 3'd4; req_rs1 = 5'd1; req_rs2 = 5'd2; req_rd = 5'd6;
        @(negedge clk);
        req_val = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_running", 32'(wb_en_Xhl), 1);
        #2 reset = 1'b0;
        #1;
        chk("abort_x", 32'(xobs()), 0);
        chk("abort_r", {16'd0, rega_addr_Rhl, regb_addr_Rhl, a_subword_off_Rhl, b_subword_off_Rhl}, 0);
        chk("abort_rdy", 32'(req_rdy), 0);
        chk("abort_done", 32'(done), 0);
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        #1 chk("abort_rel_rdy", 32'(req_rdy), 1);
        dones = 0; wbs = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            dones += int'(done);
            wbs   += int'(wb_en_Xhl);
        end
        chk("abort_no_done", 32'(dones), 0);
        chk("abort_no_wb", 32'(wbs), 0);

        // two ADDs with req_val held high
        wait_rdy();
        req_val = 1'b1; req_op = 3'd0; req_rs1 = 5'd1; req_rs2 = 5'd2; req_rd = 5'd3;
        n = 0; dones = 0; wbs = 0;
        for (int i = 0; i < 30; i++) begin
            if (n == 2) req_val = 1'b0;
            if (req_val && req_rdy) begin
                acc[n] = i;
                n++;
            end
            if (wb_en_Xhl) begin
                chk("b2b_off", 32'(wb_subword_off_Xhl), 32'(wbs % 8));
                wbs++;
            end
            dones += int'(done);
            @(negedge clk);
        end
        chk("b2b_accepts", 32'(n), 2);
        chk("b2b_gap", 32'(acc[1] - acc[0]), 32'(GAP));
        chk("b2b_dones", 32'(dones), 2);
        chk("b2b_wbs", 32'(wbs), 16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/simd_lane_uop_sequencer.md
# simd_lane_uop_sequencer

Micro-op sequencer for the 4-bit nibble-serial SIMD lane datapath. Accepts one 32-bit RISC-V-style operation (ADD/SUB/AND/OR/XOR/BNE), then walks the lane through its 8 subword offsets. It drives register addresses, subword offsets, ALU function selects, carry/flag control and writeback enables in the datapath's R and X stages. It sits between instruction decode and the lane datapath and owns all per-nibble sequencing.

## Interface
- P_NBITS, 4, lane width in bits (one nibble per micro-op)
- C_N_OFF, 8, micro-ops per 32-bit operation
- C_OFFBITS, 3, width of subword offset
- clk  in  1  sole clock, rising edge
- reset  in  1  reset, active-low, asynchronous; asserted while 0
- req_val  in  1  operation request valid
- req_rdy  out  1  sequencer can accept a request
- req_op  in  3  opcode from shared package
- req_rs1, req_rs2, req_rd  in  5 each  source and destination registers
- rega_addr_Rhl, regb_addr_Rhl  out  5 each  regfile read addresses
- a_subword_off_Rhl, b_subword_off_Rhl  out  3 each  read nibble offset
- wb_en_Xhl  out  1  nibble writeback enable
- wb_addr_Xhl  out  5, wb_subword_off_Xhl  out  3  writeback target
- addsub_fn_Xhl  out  1; logic_fn_Xhl  out  2; alu_fn_type_Xhl  out  2  ALU selects
- prop_carry_Xhl, carry_in_1_Xhl  out  1 each  carry/flag chaining
- flag_reg_en_Xhl, br_reg_en_Xhl, last_uop_Xhl  out  1 each  flag, branch and end-of-op strobes
- b_mux_sel_Xhl  out  1  1 = register operand B
- done  out  1  one-cycle pulse, operation retired

## Operation
- States: IDLE, RUN (3-bit beat counter k = 0..7), DRAIN.
- IDLE: req_rdy=1. On req_val&&req_rdy: latch op, rs1, rs2, rd; k=0; go to RUN.
- RUN: R outputs present rs1/rs2 with offset k for both a and b. k increments each cycle. At k=7, go to DRAIN.
- DRAIN: R outputs idle. X outputs carry beat 7. Go to IDLE.
- X outputs are R-stage controls registered by one cycle; offsets and addresses are zero when not valid.
- ADD: alu_fn_type=00, addsub=0. Beat 0: prop_carry=0, carry_in_1=0. Beats 1-7: prop_carry=1, carry_in_1=0.
- SUB: as ADD but addsub=1, beat 0 carry_in_1=1.
- AND/OR/XOR: alu_fn_type=01, logic_fn 00/01/10, prop_carry=0, carry_in_1=0, flag_reg_en=0.
- ADD/SUB: flag_reg_en=1 every beat.
- BNE: SUB controls with flag_reg_en=1. wb_en=0 all beats. br_reg_en=1 on beat 7 only.
- b_mux_sel=1 for all ops.
- wb_en=1 on every X beat for ADD/SUB/logic, except rd=0 (x0 never written).
- wb_subword_off equals beat index.
- last_uop_Xhl=1 and done=1 on the beat-7 X cycle.
- Unknown opcode: full 8-beat sequence with wb_en=0, flag_reg_en=0, br_reg_en=0. done still pulses.
- Reset asserted: state IDLE, all outputs 0 including req_rdy, immediately (asynchronous). Reset mid-operation aborts with no further writes and no done.

## Timing
- Accept edge E0. R beats 0..7 in cycles 1..8. X beats 0..7 in cycles 2..9.
- done/last_uop_Xhl in cycle 9. req_rdy high again in cycle 10 (macro off).
- Latency request to done: 9 cycles. Throughput: one op per 10 cycles without the macro.
- req_val without req_rdy is ignored. Request fields are sampled only at accept.

## Configuration
- SIMD_SEQ_BACK2BACK_EN defined: req_rdy is also 1 in RUN at k=7. An accept there restarts RUN at k=0 the next cycle, skipping DRAIN. The new beat 0 R overlaps the old beat 7 X. Throughput is one op per 8 cycles. done still pulses once per op.
- Undefined: req_rdy only in IDLE.

## Structure
- Shared package simd_lane_pkg holds:
  - opcode localparams (ADD=0, SUB=1, AND=2, OR=3, XOR=4, BNE=5)
  - alu_fn_type encodings (ARITH=00, LOGIC=01, SHIFT=10, JALR=11)
  - logic_fn encodings
  - P_NBITS, C_N_OFF, C_OFFBITS
- One sub-module, simd_uop_decode: combinational (op, beat index, last-beat) to control bundle.
- The top holds the FSM, the counter and the R-to-X pipeline register.

## Test plan
- ADD rs1=1, rs2=2, rd=3, accepted at E0 -> wb_en cycles 2..9 with offsets 0..7; prop_carry 0 then 1; done only in cycle 9.
- SUB rd=5 -> beat 0 carry_in_1=1, addsub=1 on all beats; beats 1..7 prop_carry=1, carry_in_1=0.
- BNE rs1=4, rs2=6 -> wb_en never 1; br_reg_en only with last_uop_Xhl in cycle 9; flag_reg_en 8 cycles.
- ADD rd=0, then opcode 7 -> zero wb_en cycles; both ops pulse done.
- reset to 0 at cycle 5 of XOR -> outputs 0 immediately; after release req_rdy=1, no done seen.
- Back-to-back ADD requests held valid -> macro on: accepts 8 cycles apart, offsets continuous; macro off: 10 cycles apart.
